mul_seq_module: RTL and testbench

//  Parametrised iterative shift-add multiplier, successor to the single-cycle registered multiplier.

---
 rtl/mul_seq_module_pkg.sv | 15 +
 rtl/mul_seq_module_abs.sv | 15 +
 rtl/mul_seq_module.sv | 108 ++++++++++
 tb/tb_mul_seq_module.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/mul_seq_module_pkg.sv
// Shared definitions for the mul_* block family: FSM state encoding and sizing helpers.
package mul_seq_module_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } mul_state_e;

    // Iteration counter width, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mul_seq_module_abs.sv
// Magnitude of a W-bit operand; two's-complement when sgn is set, passthrough otherwise.
module mul_abs #(
    parameter int W = 8
) (
    input  logic [W-1:0] x,
    input  logic         sgn,
    output logic [W-1:0] x_abs
);

    // The most negative value maps to 2^(W-1), still representable as W unsigned bits.
    always_comb begin
        x_abs = (sgn && x[W-1]) ? (~x + 1'b1) : x;
    end

endmodule

// File: rtl/mul_seq_module.sv
// Iterative shift-add multiplier retiring one multiplier bit per clock, signed or unsigned
// per transaction, with valid/ready handshakes on both sides.
module mul_seq_module
    import mul_seq_module_pkg::*;
#(
    parameter  int A_W = 8,
    parameter  int B_W = 8,
    localparam int C_W = A_W + B_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           mul_clr,
    input  logic           in_vld,
    output logic           in_rdy,
    input  logic           mul_signed,
    input  logic [A_W-1:0] mul_a,
    input  logic [B_W-1:0] mul_b,
    output logic           out_vld,
    input  logic           out_rdy,
    output logic [C_W-1:0] mul_result
);

    localparam int              CNT_W    = cnt_width(B_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(B_W - 1);

    mul_state_e       state;
    logic [C_W-1:0]   a_sh;
    logic [B_W-1:0]   b_sh;
    logic [C_W-1:0]   acc;
    logic [C_W-1:0]   acc_next;
    logic [CNT_W-1:0] cnt;
    logic             neg;
    logic [A_W-1:0]   a_abs;
    logic [B_W-1:0]   b_abs;

    mul_abs #(.W(A_W)) u_abs_a (
        .x     (mul_a),
        .sgn   (mul_signed),
        .x_abs (a_abs)
    );

    mul_abs #(.W(B_W)) u_abs_b (
        .x     (mul_b),
        .sgn   (mul_signed),
        .x_abs (b_abs)
    );

    always_comb begin
        acc_next = b_sh[0] ? (acc + a_sh) : acc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            in_rdy     <= 1'b1;
            out_vld    <= 1'b0;
            mul_result <= '0;
            a_sh       <= '0;
            b_sh       <= '0;
            acc        <= '0;
            cnt        <= '0;
            neg        <= 1'b0;
        end else if (mul_clr) begin
            // Abort discards the pending product but leaves mul_result as it was.
            state   <= ST_IDLE;
            in_rdy  <= 1'b1;
            out_vld <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (in_vld) begin
                        a_sh   <= {{B_W{1'b0}}, a_abs};
                        b_sh   <= b_abs;
                        neg    <= mul_signed & (mul_a[A_W-1] ^ mul_b[B_W-1]);
                        acc    <= '0;
                        cnt    <= '0;
                        in_rdy <= 1'b0;
                        state  <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    acc  <= acc_next;
                    a_sh <= a_sh << 1;
                    b_sh <= b_sh >> 1;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        mul_result <= neg ? (~acc_next + 1'b1) : acc_next;
                        out_vld    <= 1'b1;
                        state      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_rdy) begin
                        out_vld <= 1'b0;
                        in_rdy  <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    in_rdy  <= 1'b1;
                    out_vld <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq_module.sv
// Directed self-checking bench for mul_seq_module at the default 8x8 configuration.
module tb_mul_seq_module;

    logic        clk;
    logic        rst_n;
    logic        mul_clr;
    logic        in_vld;
    logic        in_rdy;
    logic        mul_signed;
    logic [7:0]  mul_a;
    logic [7:0]  mul_b;
    logic        out_vld;
    logic        out_rdy;
    logic [15:0] mul_result;

    int checks;
    int errors;

    mul_seq_module #(.A_W(8), .B_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mul_clr    (mul_clr),
        .in_vld     (in_vld),
        .in_rdy     (in_rdy),
        .mul_signed (mul_signed),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .out_vld    (out_vld),
        .out_rdy    (out_rdy),
        .mul_result (mul_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic s, input logic [7:0] a, input logic [7:0] b);
        int pa;
        int pb;
        if (s) begin
            pa = int'($signed(a));
            pb = int'($signed(b));
        end else begin
            pa = int'(a);
            pb = int'(b);
        end
        return 16'(pa * pb);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operand pair, wait for the accept edge, then leave the inputs scrambled.
    task automatic issue(input string tag, input logic s, input logic [7:0] a, input logic [7:0] b);
        int n;
        n = 0;
        while (!in_rdy && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_in_rdy"}, in_rdy, 1'b1);
        in_vld     = 1'b1;
        mul_signed = s;
        mul_a      = a;
        mul_b      = b;
        tick();
        in_vld     = 1'b0;
        mul_signed = ~s;
        mul_a      = ~a;
        mul_b      = a ^ b;
    endtask

    task automatic wait_result(input string tag, input logic [15:0] exp);
        int n;
        n = 0;
        while (!out_vld && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, n, 8);
        check({tag, "_result"}, mul_result, exp);
    endtask

    task automatic run_op(input string tag, input logic s, input logic [7:0] a,
                          input logic [7:0] b, input logic [15:0] exp);
        issue(tag, s, a, b);
        wait_result(tag, exp);
        tick();
        check({tag, "_vld_drop"}, out_vld, 1'b0);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        mul_clr    = 1'b0;
        in_vld     = 1'b0;
        mul_signed = 1'b0;
        mul_a      = '0;
        mul_b      = '0;
        out_rdy    = 1'b1;
        #23;
        rst_n = 1'b1;
        tick();

        check("rst_out_vld", out_vld, 1'b0);
        check("rst_result", mul_result, 16'h0000);
        check("rst_in_rdy", in_rdy, 1'b1);

        run_op("u_200x255", 1'b0, 8'd200, 8'd255, 16'hC738);
        run_op("s_m128xm128", 1'b1, 8'h80, 8'h80, 16'h4000);
        run_op("s_m3x5", 1'b1, 8'hFD, 8'h05, 16'hFFF1);
        run_op("s_127xm1", 1'b1, 8'h7F, 8'hFF, 16'hFF81);
        run_op("u_ffxff", 1'b0, 8'hFF, 8'hFF, 16'hFE01);
        run_op("u_0x5a", 1'b0, 8'h00, 8'h5A, 16'h0000);
        run_op("s_33x0", 1'b1, 8'h33, 8'h00, 16'h0000);

        // Result held in DONE while downstream stalls; stray in_vld pulses ignored.
        out_rdy = 1'b0;
        issue("hold", 1'b0, 8'd12, 8'd10);
        wait_result("hold", 16'd120);
        for (int i = 0; i < 10; i++) begin
            in_vld = (i % 2 == 0);
            mul_a  = 8'(i + 3);
            mul_b  = 8'(i + 7);
            tick();
            check("hold_out_vld", out_vld, 1'b1);
            check("hold_result", mul_result, 16'd120);
            check("hold_in_rdy", in_rdy, 1'b0);
        end
        in_vld  = 1'b0;
        out_rdy = 1'b1;
        tick();
        check("hold_release_vld", out_vld, 1'b0);
        check("hold_release_rdy", in_rdy, 1'b1);

        // Abort at cnt=3: back to idle, nothing emitted, old result kept.
        issue("clr", 1'b0, 8'd7, 8'd9);
        for (int i = 0; i < 3; i++) tick();
        mul_clr = 1'b1;
        tick();
        mul_clr = 1'b0;
        check("clr_in_rdy", in_rdy, 1'b1);
        check("clr_out_vld", out_vld, 1'b0);
        check("clr_result", mul_result, 16'd120);
        for (int i = 0; i < 10; i++) tick();
        check("clr_no_pulse", out_vld, 1'b0);
        check("clr_result_kept", mul_result, 16'd120);

        // mul_clr beats in_vld in IDLE.
        mul_clr = 1'b1;
        in_vld  = 1'b1;
        tick();
        mul_clr = 1'b0;
        in_vld  = 1'b0;
        check("clr_prio_in_rdy", in_rdy, 1'b1);
        run_op("after_clr", 1'b1, 8'hF9, 8'h06, 16'hFFD6);

        // Async reset at cnt=5.
        issue("rst", 1'b0, 8'd99, 8'd77);
        for (int i = 0; i < 5; i++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_vld", out_vld, 1'b0);
        check("arst_result", mul_result, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("arst_in_rdy", in_rdy, 1'b1);
        check("arst_no_pulse", out_vld, 1'b0);

        for (int i = 0; i < 8; i++) begin
            logic       s;
            logic [7:0] a;
            logic [7:0] b;
            s = 1'($urandom_range(0, 1));
            a = 8'($urandom);
            b = 8'($urandom);
            run_op("rand", s, a, b, model(s, a, b));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
